// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station.
// The entry holds one dispatched instruction and its operands. While it waits,
// it snoops the CDB for operands that are still pending. It asks its FU to
// execute once both operands are present, and it frees itself when its own
// ROB tag is broadcast on the CDB.
//
// Optional feature: define RS_FLUSH_EN to add a `flush` input. Flush squashes
// the entry on the next edge, exactly like reset (reset > flush > enable).
//
// Ports:
//   clk, reset (sync, active-high)
//   enable                      allocate: latch all *_in fields
//   dispatched_in               FU accepted the instruction (sticky)
//   q1/q2_valid_in, q1/q2_in    pending-operand flag and producer ROB tag
//   v1/v2_in                    operand values
//   control_signals_in          decoded control struct
//   rob_tag_in                  destination ROB tag
//   pc_plus_four_in, predicted_next_instruction_in, branch_prediction_in
//                               passthroughs for branch resolution
//   cdb_valid, cdb_rob_tag, cdb_data
//                               common data bus broadcast
//   *_out                       registered entry contents
//   busy                        entry occupied
//   ready_to_execute            request to FU, decoded from state
//   flush                       (RS_FLUSH_EN only) squash entry

package reservation_station_pkg;

  // Decoded control bundle carried alongside the instruction.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
  } control_signal_bus;

endpackage

module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef RS_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 enable,
  input  logic                 dispatched_in,
  input  logic                 q1_valid_in,
  input  logic                 q2_valid_in,
  input  logic [TAG_WIDTH-1:0] q1_in,
  input  logic [TAG_WIDTH-1:0] q2_in,
  input  logic [XLEN-1:0]      v1_in,
  input  logic [XLEN-1:0]      v2_in,
  input  control_signal_bus    control_signals_in,
  input  logic [TAG_WIDTH-1:0] rob_tag_in,
  input  logic [XLEN-1:0]      pc_plus_four_in,
  input  logic [XLEN-1:0]      predicted_next_instruction_in,
  input  logic                 branch_prediction_in,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_rob_tag,
  input  logic [XLEN-1:0]      cdb_data,
  output logic                 q1_valid_out,
  output logic                 q2_valid_out,
  output logic [TAG_WIDTH-1:0] q1_out,
  output logic [TAG_WIDTH-1:0] q2_out,
  output logic [XLEN-1:0]      v1_out,
  output logic [XLEN-1:0]      v2_out,
  output control_signal_bus    control_signals_out,
  output logic [TAG_WIDTH-1:0] rob_tag_out,
  output logic [XLEN-1:0]      pc_plus_four_out,
  output logic [XLEN-1:0]      predicted_next_instruction_out,
  output logic                 branch_prediction_out,
  output logic                 busy,
  output logic                 ready_to_execute
);

  logic dispatched;
  logic clear;

  // Squash sources; both clear the entry identically.
`ifdef RS_FLUSH_EN
  assign clear = reset | flush;
`else
  assign clear = reset;
`endif

  // CDB matches: bypass at allocation, snoop while waiting, own-tag release.
  logic bypass1, bypass2, snoop1, snoop2, release_hit;

  always_comb begin
    bypass1     = cdb_valid && q1_valid_in && (cdb_rob_tag == q1_in);
    bypass2     = cdb_valid && q2_valid_in && (cdb_rob_tag == q2_in);
    snoop1      = cdb_valid && q1_valid_out && (cdb_rob_tag == q1_out);
    snoop2      = cdb_valid && q2_valid_out && (cdb_rob_tag == q2_out);
    release_hit = busy && cdb_valid && (cdb_rob_tag == rob_tag_out) && !enable;
  end

  // Entry state register: clear > allocate > release > snoop/dispatch.
  always_ff @(posedge clk) begin
    if (clear || (!enable && release_hit)) begin
      busy                           <= 1'b0;
      dispatched                     <= 1'b0;
      q1_valid_out                   <= 1'b0;
      q2_valid_out                   <= 1'b0;
      q1_out                         <= '0;
      q2_out                         <= '0;
      v1_out                         <= '0;
      v2_out                         <= '0;
      control_signals_out            <= '0;
      rob_tag_out                    <= '0;
      pc_plus_four_out               <= '0;
      predicted_next_instruction_out <= '0;
      branch_prediction_out          <= 1'b0;
    end else if (enable) begin
      busy                           <= 1'b1;
      dispatched                     <= 1'b0;
      q1_valid_out                   <= bypass1 ? 1'b0 : q1_valid_in;
      q2_valid_out                   <= bypass2 ? 1'b0 : q2_valid_in;
      q1_out                         <= bypass1 ? '0 : q1_in;
      q2_out                         <= bypass2 ? '0 : q2_in;
      v1_out                         <= bypass1 ? cdb_data : v1_in;
      v2_out                         <= bypass2 ? cdb_data : v2_in;
      control_signals_out            <= control_signals_in;
      rob_tag_out                    <= rob_tag_in;
      pc_plus_four_out               <= pc_plus_four_in;
      predicted_next_instruction_out <= predicted_next_instruction_in;
      branch_prediction_out          <= branch_prediction_in;
    end else if (busy) begin
      if (snoop1) begin
        v1_out       <= cdb_data;
        q1_out       <= '0;
        q1_valid_out <= 1'b0;
      end
      if (snoop2) begin
        v2_out       <= cdb_data;
        q2_out       <= '0;
        q2_valid_out <= 1'b0;
      end
      if (dispatched_in) begin
        dispatched <= 1'b1;
      end
    end
  end

  // FU request: entry present, no pending operand, not yet accepted.
  assign ready_to_execute = busy & ~q1_valid_out & ~q2_valid_out & ~dispatched;

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_WIDTH = 32;
  localparam int unsigned NVEC      = 25;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 enable, dispatched_in;
  logic                 q1_valid_in, q2_valid_in;
  logic [TAG_WIDTH-1:0] q1_in, q2_in, rob_tag_in, cdb_rob_tag;
  logic [XLEN-1:0]      v1_in, v2_in, pc_plus_four_in, predicted_next_instruction_in, cdb_data;
  control_signal_bus    control_signals_in, control_signals_out;
  logic                 branch_prediction_in, cdb_valid;
  logic                 q1_valid_out, q2_valid_out;
  logic [TAG_WIDTH-1:0] q1_out, q2_out, rob_tag_out;
  logic [XLEN-1:0]      v1_out, v2_out, pc_plus_four_out, predicted_next_instruction_out;
  logic                 branch_prediction_out, busy, ready_to_execute;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reservation_station #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk                            (clk),
`ifdef RS_FLUSH_EN
    .reset                          (reset),
    .flush                          (flush),
`else
    .reset                          (reset | flush),
`endif
    .enable                         (enable),
    .dispatched_in                  (dispatched_in),
    .q1_valid_in                    (q1_valid_in),
    .q2_valid_in                    (q2_valid_in),
    .q1_in                          (q1_in),
    .q2_in                          (q2_in),
    .v1_in                          (v1_in),
    .v2_in                          (v2_in),
    .control_signals_in             (control_signals_in),
    .rob_tag_in                     (rob_tag_in),
    .pc_plus_four_in                (pc_plus_four_in),
    .predicted_next_instruction_in  (predicted_next_instruction_in),
    .branch_prediction_in           (branch_prediction_in),
    .cdb_valid                      (cdb_valid),
    .cdb_rob_tag                    (cdb_rob_tag),
    .cdb_data                       (cdb_data),
    .q1_valid_out                   (q1_valid_out),
    .q2_valid_out                   (q2_valid_out),
    .q1_out                         (q1_out),
    .q2_out                         (q2_out),
    .v1_out                         (v1_out),
    .v2_out                         (v2_out),
    .control_signals_out            (control_signals_out),
    .rob_tag_out                    (rob_tag_out),
    .pc_plus_four_out               (pc_plus_four_out),
    .predicted_next_instruction_out (predicted_next_instruction_out),
    .branch_prediction_out          (branch_prediction_out),
    .busy                           (busy),
    .ready_to_execute               (ready_to_execute)
  );

  // One clock of stimulus and the entry state expected after that edge.
  typedef struct {
    bit [31:0] rst, en, dsp, q1v, q1, q2v, q2, v1, v2, rob, f3, pc, cv, ct, cd, fl;
    bit [31:0] e_busy, e_q1v, e_q1, e_q2v, e_q2, e_v1, e_v2, e_rob, e_f3, e_pc, e_rdy;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic drive(input vec_t v);
    reset                         = v.rst[0];
    flush                         = v.fl[0];
    enable                        = v.en[0];
    dispatched_in                 = v.dsp[0];
    q1_valid_in                   = v.q1v[0];
    q1_in                         = v.q1;
    q2_valid_in                   = v.q2v[0];
    q2_in                         = v.q2;
    v1_in                         = v.v1;
    v2_in                         = v.v2;
    rob_tag_in                    = v.rob;
    control_signals_in            = '0;
    control_signals_in.funct3     = v.f3[2:0];
    pc_plus_four_in               = v.pc;
    predicted_next_instruction_in = v.pc + 32'd8;
    branch_prediction_in          = v.pc[2];
    cdb_valid                     = v.cv[0];
    cdb_rob_tag                   = v.ct;
    cdb_data                      = v.cd;
  endtask

  // Compare the full entry against expectations; passthroughs follow from pc.
  task automatic check(input string name, input vec_t v);
    control_signal_bus e_ctrl;
    bit ok;
    e_ctrl        = '0;
    e_ctrl.funct3 = v.e_f3[2:0];
    ok = (busy == v.e_busy[0]) && (q1_valid_out == v.e_q1v[0]) && (q1_out == v.e_q1) &&
         (q2_valid_out == v.e_q2v[0]) && (q2_out == v.e_q2) && (v1_out == v.e_v1) &&
         (v2_out == v.e_v2) && (rob_tag_out == v.e_rob) && (control_signals_out == e_ctrl) &&
         (pc_plus_four_out == v.e_pc) &&
         (predicted_next_instruction_out == ((v.e_pc == 0) ? 32'd0 : v.e_pc + 32'd8)) &&
         (branch_prediction_out == v.e_pc[2]) && (ready_to_execute == v.e_rdy[0]);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got busy=%0d q1v=%0d q1=%0d q2v=%0d q2=%0d v1=%0d v2=%0d rob=%0d f3=%0d pc=%0d rdy=%0d want busy=%0d q1v=%0d q1=%0d q2v=%0d q2=%0d v1=%0d v2=%0d rob=%0d f3=%0d pc=%0d rdy=%0d",
               name, busy, q1_valid_out, q1_out, q2_valid_out, q2_out, v1_out, v2_out,
               rob_tag_out, control_signals_out.funct3, pc_plus_four_out, ready_to_execute,
               v.e_busy, v.e_q1v, v.e_q1, v.e_q2v, v.e_q2, v.e_v1, v.e_v2, v.e_rob, v.e_f3,
               v.e_pc, v.e_rdy);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t h;
    //            rst en dsp q1v q1 q2v q2 v1 v2 rob f3 pc  cv ct cd fl | busy q1v q1 q2v q2 v1  v2  rob f3 pc  rdy
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[1]  = '{0, 1, 0, 1, 1, 1, 2, 0, 0, 7,  5, 100, 0, 0, 0,  0,   1, 1, 1, 1, 2, 0,  0,  7,  5, 100, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 2, 99, 0,   1, 1, 1, 1, 2, 0,  0,  7,  5, 100, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 2, 4,  0,   1, 1, 1, 0, 0, 0,  4,  7,  5, 100, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 3, 5,  0,   1, 1, 1, 0, 0, 0,  4,  7,  5, 100, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 1, 19, 0,   1, 0, 0, 0, 0, 19, 4,  7,  5, 100, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   1, 0, 0, 0, 0, 19, 4,  7,  5, 100, 1};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   1, 0, 0, 0, 0, 19, 4,  7,  5, 100, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   1, 0, 0, 0, 0, 19, 4,  7,  5, 100, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 7, 55, 0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[10] = '{0, 1, 0, 1, 3, 1, 4, 0, 0, 19, 2, 200, 1, 4, 81, 0,   1, 1, 3, 0, 0, 0,  81, 19, 2, 200, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 4, 1,  0,   1, 1, 3, 0, 0, 0,  81, 19, 2, 200, 0};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 0, 9, 12, 3, 1, 300, 0, 0, 0,  0,   1, 0, 0, 0, 0, 9,  12, 3,  1, 300, 1};
    vecs[14] = '{0, 1, 0, 1, 5, 1, 5, 0, 0, 8,  7, 400, 0, 0, 0,  0,   1, 1, 5, 1, 5, 0,  0,  8,  7, 400, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 5, 33, 0,   1, 0, 0, 0, 0, 33, 33, 8,  7, 400, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 8, 0,  0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[17] = '{0, 1, 0, 1, 0, 0, 0, 0, 6, 0,  3, 500, 1, 0, 42, 0,   1, 0, 0, 0, 0, 42, 6,  0,  3, 500, 1};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   1, 0, 1,  0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[19] = '{0, 1, 0, 0, 0, 0, 0, 1, 2, 11, 4, 600, 0, 0, 0,  0,   1, 0, 0, 0, 0, 1,  2,  11, 4, 600, 1};
    vecs[20] = '{0, 1, 0, 0, 0, 0, 0, 7, 8, 12, 6, 700, 1, 11, 9, 0,   1, 0, 0, 0, 0, 7,  8,  12, 6, 700, 1};
    vecs[21] = '{0, 1, 0, 1, 6, 0, 0, 0, 0, 13, 1, 800, 0, 0, 0,  0,   1, 1, 6, 0, 0, 0,  0,  13, 1, 800, 0};
    vecs[22] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};
    vecs[23] = '{0, 1, 0, 0, 0, 1, 9, 5, 0, 14, 2, 900, 0, 0, 0,  0,   1, 0, 0, 1, 9, 5,  0,  14, 2, 900, 0};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  1,   0, 0, 0, 0, 0, 0,  0,  0,  0, 0,   0};

    h = vecs[0];
    drive(h);
    for (int i = 0; i < int'(NVEC); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Ready holds across idle cycles and non-matching CDB traffic.
    h = '{0, 1, 0, 0, 0, 0, 0, 3, 4, 20, 5, 1000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 4, 20, 5, 1000, 1};
    step("hold_alloc", h);
    h.en = 0; h.v1 = 0; h.v2 = 0; h.rob = 0; h.f3 = 0; h.pc = 0;
    h.cv = 1; h.ct = 21; h.cd = 77;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold%0d", i), h);
    end
    // Dispatch drops ready but keeps the entry until its own tag is broadcast.
    h.cv = 0; h.dsp = 1; h.e_rdy = 0;
    step("hold_dispatch", h);
    h.dsp = 0; h.cv = 1; h.ct = 20; h.cd = 5;
    h.e_busy = 0; h.e_v1 = 0; h.e_v2 = 0; h.e_rob = 0; h.e_f3 = 0; h.e_pc = 0;
    step("hold_release", h);

    // Squash beats a simultaneous allocation.
    h = '{0, 1, 0, 1, 2, 0, 0, 0, 1, 30, 4, 1100, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1, 30, 4, 1100, 0};
    step("prio_alloc", h);
    h.fl = 1;
    h.e_busy = 0; h.e_q1v = 0; h.e_q1 = 0; h.e_v2 = 0; h.e_rob = 0; h.e_f3 = 0; h.e_pc = 0;
    step("prio_flush_vs_enable", h);
    h.fl = 0; h.rst = 1;
    step("prio_reset_vs_enable", h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
